map_keeper: RTL and testbench

- Owns the 20x15 tile map (300 entries, index = y*20 + x) that both tanks read for movement and bullet collision.
- Applies brick-destroy reports (`change`) from both tanks and queues destroyed bricks for timed regrowth.
- On a restart pulse, re-sweeps the whole map back to the level image.
- Sits between the two tank instances and the map renderer/game-state logic; this is the writer side of the map each tank reads.

---
 rtl/map_pkg.sv | 49 ++++
 rtl/map_keeper_regrow_fifo.sv | 56 +++++
 rtl/map_keeper.sv | 134 +++++++++++++
 tb/tb_map_keeper.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared map constants, tile codes, the level image and the regrow queue entry.
package map_pkg;

    localparam int MAP_W   = 20;
    localparam int MAP_H   = 15;
    localparam int MAP_N   = MAP_W * MAP_H;
    localparam int STAMP_W = 16;

    localparam logic [2:0] T_EMPTY = 3'd0;
    localparam logic [2:0] T_WALL  = 3'd1;
    localparam logic [2:0] T_BRICK = 3'd2;
    localparam logic [2:0] T_BASE2 = 3'd3;
    localparam logic [2:0] T_BASE1 = 3'd4;

    typedef enum logic {S_PLAY, S_LOAD} mk_state_t;

    typedef struct packed {
        int                 idx;
        logic [STAMP_W-1:0] stamp;
    } regrow_entry_t;

    typedef logic [MAP_N-1:0][2:0] level_t;

    // Border of walls, two bases, a short brick row; tank start tiles stay empty.
    function automatic level_t build_level();
        level_t l;
        int     x, y;
        for (int i = 0; i < MAP_N; i++) begin
            x = i % MAP_W;
            y = i / MAP_W;
            l[i] = (x == 0 || y == 0 || x == MAP_W-1 || y == MAP_H-1) ? T_WALL : T_EMPTY;
        end
        l[22]  = T_BASE2;
        l[277] = T_BASE1;
        l[105] = T_BRICK;
        l[106] = T_BRICK;
        l[107] = T_BRICK;
        return l;
    endfunction

    localparam level_t LEVEL0 = build_level();

    // Tile index of a tank, -1 when it is off the map.
    function automatic int tile_of(int x, int y);
        if (x < 0 || y < 0 || x >= MAP_W || y >= MAP_H) return -1;
        return y * MAP_W + x;
    endfunction

endpackage

// File: rtl/map_keeper_regrow_fifo.sv
// Circular queue of destroyed bricks; up to two pushes and one pop per frame.
module regrow_fifo
    import map_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic          flush,
    input  logic          push_a,
    input  logic          push_b,
    input  logic          pop,
    input  regrow_entry_t din_a,
    input  regrow_entry_t din_b,
    output regrow_entry_t head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    regrow_entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp, wp_b;

    // The second entry lands one slot past the first when both push.
    assign wp_b = push_a ? wp + AW'(1) : wp;

    // Storage needs no reset; the count decides what is valid.
    always_ff @(posedge frame_clk) begin
        if (!flush) begin
            if (push_a) mem[wp]   <= din_a;
            if (push_b) mem[wp_b] <= din_b;
        end
    end

    // Pointers and occupancy; push and pop may coincide.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push_a) + AW'(push_b);
            rp    <= rp + AW'(pop);
            count <= count + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(pop);
        end
    end

    assign head  = mem[rp];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/map_keeper.sv
// Writer side of the tile map: brick destruction, timed regrowth, level reload.
module map_keeper
    import map_pkg::*;
#(
    parameter int REGROW_FRAMES = 240,
    parameter int DEPTH         = 8,
    parameter int CNT_W         = STAMP_W
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       restart,
    input  int         change1,
    input  int         change2,
    input  int         tank1X,
    input  int         tank1Y,
    input  int         tank2X,
    input  int         tank2Y,
    output int         map_out [MAP_N],
    output logic       busy,
    output logic [3:0] pending,
    output logic       overflow
);
    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] REGROW_C = CNT_W'(REGROW_FRAMES);

    mk_state_t        state, state_n;
    level_t           map_q;
    logic [CNT_W-1:0] cnt, age;
    logic [8:0]       sweep, c1, c2, head_i;
    logic             play_en, load_wr, flush;
    logic             v1, v2, want_b, push_a, push_b, drop, regrow;
    logic             q_full, q_empty;
    logic [AW:0]      q_cnt;
    int               t1_idx, t2_idx;
    regrow_entry_t    head, din_a, din_b;

    assign c1     = change1[8:0];
    assign c2     = change2[8:0];
    assign t1_idx = tile_of(tank1X, tank1Y);
    assign t2_idx = tile_of(tank2X, tank2Y);
    assign head_i = head.idx[8:0];
    assign age    = cnt - CNT_W'(head.stamp);

    // A report only counts when it names a live brick.
    assign v1 = play_en && change1 >= 1 && change1 < MAP_N && map_q[c1] == T_BRICK;
    assign v2 = play_en && change2 >= 1 && change2 < MAP_N && map_q[c2] == T_BRICK;

    // Same tile from both tanks is one event; change1 wins the last free slot.
    assign want_b = v2 && !(v1 && change1 == change2);
    assign push_a = v1 && !q_full;
    assign push_b = want_b && (v1 ? (q_cnt <= (AW+1)'(DEPTH-2)) : !q_full);
    assign drop   = (v1 && !push_a) || (want_b && !push_b);

    // Only the head can be due: every entry carries the same delay.
    assign regrow = play_en && !q_empty && age >= REGROW_C &&
                    head.idx != t1_idx && head.idx != t2_idx;

    assign din_a = '{idx: change1, stamp: STAMP_W'(cnt)};
    assign din_b = '{idx: change2, stamp: STAMP_W'(cnt)};

    regrow_fifo #(.DEPTH(DEPTH)) u_fifo (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .flush     (flush),
        .push_a    (push_a),
        .push_b    (push_b),
        .pop       (regrow),
        .din_a     (din_a),
        .din_b     (din_b),
        .head      (head),
        .count     (q_cnt),
        .full      (q_full),
        .empty     (q_empty)
    );

    // State register.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) state <= S_PLAY;
        else       state <= state_n;
    end

    // Next state: restart starts a sweep, the last tile ends it.
    always_comb begin
        state_n = state;
        case (state)
            S_PLAY: if (restart)                state_n = S_LOAD;
            S_LOAD: if (sweep == 9'(MAP_N-1))   state_n = S_PLAY;
            default:                            state_n = S_PLAY;
        endcase
    end

    // Control decode; the restart frame itself does no gameplay updates.
    always_comb begin
        play_en = (state == S_PLAY) && !restart;
        flush   = (state == S_PLAY) && restart;
        load_wr = (state == S_LOAD);
    end

    // Frame counter, sweep pointer, busy and sticky overflow.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            sweep    <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cnt      <= cnt + CNT_W'(1);
            busy     <= (state_n == S_LOAD);
            sweep    <= flush ? 9'd0 : (load_wr ? sweep + 9'd1 : sweep);
            overflow <= flush ? 1'b0 : (overflow | drop);
        end
    end

    // Map contents: full image on reset, one tile per frame while sweeping.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            map_q <= LEVEL0;
        end else if (load_wr) begin
            map_q[sweep] <= LEVEL0[sweep];
        end else begin
            if (v1)     map_q[c1]     <= T_EMPTY;
            if (v2)     map_q[c2]     <= T_EMPTY;
            if (regrow) map_q[head_i] <= T_BRICK;
        end
    end

    // Widen tile codes onto the int map port.
    always_comb begin
        for (int i = 0; i < MAP_N; i++) map_out[i] = int'(map_q[i]);
    end

    assign pending = 4'(q_cnt);

endmodule

// File: tb/tb_map_keeper.sv
// Directed scoreboard bench for map_keeper.
module tb_map_keeper;
    import map_pkg::*;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic       restart   = 1'b0;
    int         change1 = 0, change2 = 0;
    int         tank1X = -1, tank1Y = -1, tank2X = -1, tank2Y = -1;
    int         map_out [MAP_N];
    logic       busy, overflow;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    sel;   // 0 map tile, 1 pending, 2 overflow, 3 busy
        int    idx;
        int    val;
    } exp_t;
    exp_t   sb[$];
    level_t forced_map;

    map_keeper dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .restart   (restart),
        .change1   (change1),
        .change2   (change2),
        .tank1X    (tank1X),
        .tank1Y    (tank1Y),
        .tank2X    (tank2X),
        .tank2Y    (tank2Y),
        .map_out   (map_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 frame_clk = ~frame_clk;

    // Independent model of the level image.
    function automatic int lvl(int i);
        int x, y;
        x = i % 20;
        y = i / 20;
        if (i == 22) return 3;
        if (i == 277) return 4;
        if (i >= 105 && i <= 107) return 2;
        if (x == 0 || y == 0 || x == 19 || y == 14) return 1;
        return 0;
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic tick_n(int n);
        repeat (n) tick();
    endtask

    task automatic want(string tag, int sel, int idx, int val);
        sb.push_back('{tag, sel, idx, val});
    endtask

    task automatic want_level(string tag);
        for (int i = 0; i < MAP_N; i++) want(tag, 0, i, lvl(i));
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e;
            int   obs;
            e = sb.pop_front();
            case (e.sel)
                0:       obs = map_out[e.idx];
                1:       obs = int'(pending);
                2:       obs = int'(overflow);
                default: obs = int'(busy);
            endcase
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s[%0d]: got %0d expected %0d", e.tag, e.idx, obs, e.val);
            end
        end
    endtask

    initial begin
        // Reset state
        tick_n(2);
        want("rst_map", 0, 0, 1);   want("rst_map", 0, 22, 3);
        want("rst_map", 0, 105, 2); want("rst_map", 0, 261, 0);
        want("rst_map", 0, 277, 4); want("rst_map", 0, 38, 0);
        want("rst_pend", 1, 0, 0);  want("rst_ovf", 2, 0, 0); want("rst_busy", 3, 0, 0);
        drain();
        Reset = 1'b0;
        tick();

        // Single destroy and regrow after exactly 240 frames
        change1 = 105;
        want("d105", 0, 105, 0); want("d105_pend", 1, 0, 1);
        tick(); drain();
        change1 = 0;
        tick_n(238);
        want("d105_early", 0, 105, 0);
        tick(); drain();
        want("d105_regrow", 0, 105, 2); want("d105_pend0", 1, 0, 0);
        tick(); drain();

        // Same tile from both tanks, then a non-brick report
        change1 = 106; change2 = 106;
        want("dup106", 0, 106, 0); want("dup_pend", 1, 0, 1);
        tick(); drain();
        change1 = 0; change2 = 22;
        want("base22", 0, 22, 3); want("base_pend", 1, 0, 1); want("base_ovf", 2, 0, 0);
        tick(); drain();
        change2 = 0;
        tick_n(237);
        want("d106_early", 0, 106, 0);
        tick(); drain();
        want("d106_regrow", 0, 106, 2); want("d106_pend0", 1, 0, 0);
        tick(); drain();

        // Tanks sitting on the due tile hold the regrowth
        tank1X = 5; tank1Y = 5; change1 = 105;
        want("blk105", 0, 105, 0); want("blk_pend", 1, 0, 1);
        tick(); drain();
        change1 = 0;
        tick_n(199);
        tank1X = -1; tank1Y = -1; tank2X = 5; tank2Y = 5;
        tick_n(59);
        want("blk_hold", 0, 105, 0); want("blk_hold_pend", 1, 0, 1);
        tick(); drain();
        tank2X = -1; tank2Y = -1;
        want("blk_clear", 0, 105, 2); want("blk_clear_pend", 1, 0, 0);
        tick(); drain();

        // Fill the queue from forced bricks, then overflow
        for (int i = 0; i < MAP_N; i++) forced_map[i] = 3'(lvl(i));
        for (int i = 110; i < 118; i++) forced_map[i] = 3'd2;
        force dut.map_q = forced_map;
        for (int k = 0; k < 4; k++) begin
            change1 = 110 + 2*k;
            change2 = 111 + 2*k;
            want("fill_pend", 1, 0, 2*k + 2);
            want("fill_ovf", 2, 0, 0);
            tick(); drain();
        end
        release dut.map_q;
        change1 = 107; change2 = 0;
        want("ovf107", 0, 107, 0); want("ovf_flag", 2, 0, 1); want("ovf_pend", 1, 0, 8);
        tick(); drain();
        change1 = 0;

        // Async reset restores everything without a clock edge
        Reset = 1'b1;
        #1;
        want("rst2_107", 0, 107, 2); want("rst2_pend", 1, 0, 0); want("rst2_ovf", 2, 0, 0);
        drain();
        Reset = 1'b0;
        tick();

        // Reload sweep with two pending entries
        change1 = 105; change2 = 106;
        want("pre_pend", 1, 0, 2); want("pre105", 0, 105, 0); want("pre106", 0, 106, 0);
        tick(); drain();
        change1 = 0; change2 = 0;
        restart = 1'b1;
        want("ld_busy", 3, 0, 1); want("ld_pend", 1, 0, 0); want("ld_ovf", 2, 0, 0);
        tick(); drain();
        restart = 1'b0;
        tick_n(198);
        want("ld_busy198", 3, 0, 1);
        tick(); drain();
        change1 = 107;
        tick();
        change1 = 0;
        tick_n(49);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tick_n(48);
        want("ld_busy299", 3, 0, 1);
        tick(); drain();
        want("ld_done", 3, 0, 0); want("ld_pend0", 1, 0, 0);
        want_level("ld_map");
        tick(); drain();

        // Reset in the middle of a sweep
        change1 = 105;
        tick();
        change1 = 0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tick_n(150);
        want("mid_busy", 3, 0, 1);
        drain();
        Reset = 1'b1;
        #1;
        want("abort_busy", 3, 0, 0); want("abort_pend", 1, 0, 0);
        want_level("abort_map");
        drain();
        Reset = 1'b0;
        want("abort_play", 3, 0, 0);
        tick(); drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
